// File: rtl/buffer_pkg.sv
// Shared sizing constants and helpers for the team's FIFO and LIFO buffers.
`default_nettype none

package buffer_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_DEPTH      = 8;

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

`default_nettype wire

// File: rtl/queue_regfile.sv
// DEPTH x DATA_WIDTH storage: one synchronous write port, one combinational read port.
`default_nettype none

module queue_regfile
  import buffer_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int PTR_W      = ptr_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [PTR_W-1:0]      waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [PTR_W-1:0]      raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  // Array is deliberately left without reset; the pointers define validity.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/queue_fifo.sv
// Synchronous FIFO with occupancy count and one-cycle overflow/underflow pulses.
`default_nettype none

module queue_fifo
  import buffer_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_WIDTH-1:0]      data_in,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  push_ok, pop_ok;
  logic [DATA_WIDTH-1:0] rdata;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));

  // A pop frees a slot in the same edge, so a push into a full queue is legal then.
  assign push_ok = push & (~full | pop);
  assign pop_ok  = pop & ~empty;

  queue_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .PTR_W      (PTR_W)
  ) u_regfile (
    .clk     (clk),
    .we_i    (push_ok),
    .waddr_i (wr_ptr_q),
    .wdata_i (data_in),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata)
  );

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    data_out_d  = data_out_q;
    count_d     = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    overflow_d  = push & ~push_ok;
    underflow_d = pop & ~pop_ok;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d   = rd_ptr_q + 1'b1;
      data_out_d = rdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign data_out  = data_out_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

`default_nettype wire
